// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: PC / IF-ID enables and IF-ID / ID-EX flushes for load-use, taken branch and multi-cycle EX ops.
// Optional HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int RW         = 3,
  parameter int FLUSH_CYC  = 1,
  parameter int MC_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic          ex_valid,
  input  logic          ex_is_load,
  input  logic [RW-1:0] ex_rd,
  input  logic          br_taken,
  input  logic          mc_start,
  input  logic          mc_done,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          mc_busy,
  output logic          mc_err,
  output logic [1:0]    state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
`endif
);

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_FLUSH   = 2'b01;
  localparam logic [1:0] S_MC_WAIT = 2'b10;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);
  localparam logic [7:0] MC_LAST      = 8'(MC_TIMEOUT - 1);

  logic [1:0] r_state;
  logic [3:0] r_fcnt;
  logic [7:0] r_mcnt;
  logic       r_mc_err;

  logic [1:0] w_next_state;
  logic [3:0] w_next_fcnt;
  logic [7:0] w_next_mcnt;
  logic       w_set_err;
  logic       w_br_acc;
  logic       w_lu;
  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_ifid_flush;
  logic       w_idex_flush;
  logic       w_mc_busy;

  // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_lu = ex_valid && ex_is_load && (ex_rd != '0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_mc_busy    = 1'b0;
    w_next_state = r_state;
    w_next_fcnt  = r_fcnt;
    w_next_mcnt  = r_mcnt;
    w_set_err    = 1'b0;
    w_br_acc     = 1'b0;

    case (r_state)
      S_RUN: begin
        if (br_taken) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_br_acc     = 1'b1;
          if (FLUSH_CYC > 1) begin
            w_next_state = S_FLUSH;
            w_next_fcnt  = FLUSH_RELOAD;
          end
        end else if (w_lu) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
        end else if (mc_start) begin
          w_next_state = S_MC_WAIT;
          w_next_mcnt  = '0;
        end
      end

      S_FLUSH: begin
        w_ifid_flush = 1'b1;
        if (br_taken) begin
          w_idex_flush = 1'b1;
          w_br_acc     = 1'b1;
          w_next_fcnt  = FLUSH_RELOAD;
        end else if (r_fcnt <= 4'd1) begin
          w_next_state = S_RUN;
          w_next_fcnt  = '0;
        end else begin
          w_next_fcnt  = r_fcnt - 4'd1;
        end
      end

      S_MC_WAIT: begin
        if (mc_done) begin
          w_next_state = S_RUN;
          w_next_mcnt  = '0;
        end else if (r_mcnt >= MC_LAST) begin
          w_set_err    = 1'b1;
          w_next_state = S_RUN;
          w_next_mcnt  = '0;
        end else begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
          w_mc_busy    = 1'b1;
          w_next_mcnt  = r_mcnt + 8'd1;
        end
      end

      default: w_next_state = S_RUN;
    endcase

    if (rst) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_mc_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state  <= S_RUN;
      r_fcnt   <= '0;
      r_mcnt   <= '0;
      r_mc_err <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_fcnt   <= w_next_fcnt;
      r_mcnt   <= w_next_mcnt;
      if (w_set_err) r_mc_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_br_acc && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign pc_en      = w_pc_en;
  assign ifid_en    = w_ifid_en;
  assign ifid_flush = w_ifid_flush;
  assign idex_flush = w_idex_flush;
  assign mc_busy    = w_mc_busy;
  assign mc_err     = r_mc_err;
  assign state      = r_state;

endmodule
